// File: rtl/handshake_rr_arbiter_if.sv
// Handshake bundle between NUM_CH upstream requesters and one downstream channel.
// master drives requests and downstream ready; slave is the arbiter.
interface handshake_rr_arbiter_if #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned WORD_WIDTH = 32
);
    logic [NUM_CH-1:0]            up_valid;
    logic [NUM_CH*WORD_WIDTH-1:0] up_data;
    logic [NUM_CH-1:0]            up_last;
    logic [NUM_CH-1:0]            up_ready;
    logic                         down_valid;
    logic [WORD_WIDTH-1:0]        down_data;
    logic                         down_last;
    logic                         down_ready;

    modport master (
        output up_valid, up_data, up_last, down_ready,
        input  up_ready, down_valid, down_data, down_last
    );

    modport slave (
        input  up_valid, up_data, up_last, down_ready,
        output up_ready, down_valid, down_data, down_last
    );
endinterface

// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready channel among NUM_CH requesters.
// Define ARB_LOCK_EN to hold each grant until the up_last beat; otherwise re-arbitrate per beat.
module handshake_rr_arbiter #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned WORD_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    handshake_rr_arbiter_if.slave  bus,
    output logic [NUM_CH-1:0]      grant,
    output logic                   busy
);
    localparam int unsigned PTR_W = $clog2(NUM_CH);
    localparam int unsigned SUM_W = PTR_W + 1;

    typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t               state;
    state_t               state_next;
    logic [PTR_W-1:0]     ptr;
    logic [PTR_W-1:0]     ptr_next;
    logic [PTR_W-1:0]     g_idx;
    logic [PTR_W-1:0]     g_idx_next;
    logic [NUM_CH-1:0]    grant_next;

    logic [2*NUM_CH-1:0]  req_rot;
    logic [NUM_CH-1:0]    req_scan;
    logic                 found;
    logic [PTR_W-1:0]     off;
    logic [SUM_W-1:0]     pick_sum;
    logic [PTR_W-1:0]     pick;
    logic                 accept;
    logic                 done_beat;

    // State, pointer and grant registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            g_idx <= '0;
            grant <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            g_idx <= g_idx_next;
            grant <= grant_next;
            busy  <= (state_next == GRANT);
        end
    end

    // Round-robin search: rotate requests so ptr sits at bit 0, take the lowest set bit.
    always_comb begin
        req_rot  = {bus.up_valid, bus.up_valid} >> ptr;
        req_scan = req_rot[NUM_CH-1:0];
        found    = 1'b0;
        off      = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (!found && req_scan[0]) begin
                found = 1'b1;
                off   = PTR_W'(k);
            end
            req_scan = req_scan >> 1;
        end
        pick_sum = {1'b0, ptr} + {1'b0, off};
        if (pick_sum >= SUM_W'(NUM_CH)) begin
            pick_sum = pick_sum - SUM_W'(NUM_CH);
        end
        pick = pick_sum[PTR_W-1:0];
    end

    assign accept = bus.down_valid & bus.down_ready;
`ifdef ARB_LOCK_EN
    assign done_beat = accept & bus.down_last;
`else
    assign done_beat = accept;
`endif

    // Next-state logic.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        g_idx_next = g_idx;
        grant_next = grant;
        case (state)
            IDLE: begin
                if (found) begin
                    state_next = GRANT;
                    g_idx_next = pick;
                    grant_next = NUM_CH'(1) << pick;
                end
            end
            GRANT: begin
                if (done_beat) begin
                    state_next = IDLE;
                    grant_next = '0;
                    // NUM_CH need not be a power of two, so wrap explicitly.
                    if (g_idx == PTR_W'(NUM_CH - 1)) begin
                        ptr_next = '0;
                    end else begin
                        ptr_next = g_idx + PTR_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    // Handshake outputs; grant is zero in IDLE so the masks close everything.
    always_comb begin
        bus.down_valid = 1'b0;
        bus.down_last  = 1'b0;
        bus.up_ready   = '0;
        if (state == GRANT) begin
            bus.down_valid = |(bus.up_valid & grant);
            bus.down_last  = |(bus.up_last & grant);
            bus.up_ready   = grant & {NUM_CH{bus.down_ready}};
        end
    end

    // One-hot AND-OR data mux.
    logic [WORD_WIDTH-1:0] data_chain [NUM_CH+1];
    assign data_chain[0] = '0;
    for (genvar i = 0; i < NUM_CH; i++) begin : g_mux
        assign data_chain[i+1] = data_chain[i]
                               | (bus.up_data[i*WORD_WIDTH +: WORD_WIDTH] & {WORD_WIDTH{grant[i]}});
    end
    assign bus.down_data = data_chain[NUM_CH];

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Directed bench for handshake_rr_arbiter: 4-channel instance plus a 3-channel wrap instance.
// Lock-dependent expectations follow the ARB_LOCK_EN build.
module tb_handshake_rr_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    handshake_rr_arbiter_if #(.NUM_CH(4), .WORD_WIDTH(32)) b4();
    handshake_rr_arbiter_if #(.NUM_CH(3), .WORD_WIDTH(8))  b3();

    logic [3:0] grant4;
    logic       busy4;
    logic [2:0] grant3;
    logic       busy3;

    handshake_rr_arbiter #(.NUM_CH(4), .WORD_WIDTH(32)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .bus(b4), .grant(grant4), .busy(busy4)
    );
    handshake_rr_arbiter #(.NUM_CH(3), .WORD_WIDTH(8)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .bus(b3), .grant(grant3), .busy(busy3)
    );

    int n_chk = 0;
    int n_err = 0;
    int beat  = 0;
    bit model_on = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Channel 1 packet source: 5 beats 0x100..0x104, last on the fifth.
    task automatic set_ch1();
        b4.up_data[32 +: 32] = 32'h100 + 32'(beat);
        b4.up_last[1]        = (beat == 4);
        b4.up_valid[1]       = (beat < 5);
    endtask

    task automatic step();
        logic acc;
        acc = b4.up_valid[1] & b4.up_ready[1];
        @(posedge clk);
        #2;
        if (model_on && acc) begin
            beat++;
            set_ch1();
        end
        #1;
    endtask

    initial begin
        logic [3:0] exp_g;
        int         ch;

        rst_n         = 1'b0;
        b4.up_valid   = 4'hF;
        b4.up_last    = 4'hF;
        b4.up_data    = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        b4.down_ready = 1'b1;
        b3.up_valid   = 3'b000;
        b3.up_last    = 3'b111;
        b3.up_data    = {8'h32, 8'h31, 8'h30};
        b3.down_ready = 1'b1;
        #2;
        chk("rst_grant", 64'(grant4), 64'h0);
        chk("rst_busy", 64'(busy4), 64'h0);
        chk("rst_up_ready", 64'(b4.up_ready), 64'h0);
        chk("rst_down_valid", 64'(b4.down_valid), 64'h0);

        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        chk("post_rst_idle", 64'(grant4), 64'h0);

        // First grant one cycle after release goes to ch0.
        step();
        chk("first_grant", 64'(grant4), 64'h1);
        chk("first_busy", 64'(busy4), 64'h1);
        chk("first_valid", 64'(b4.down_valid), 64'h1);
        chk("first_ready", 64'(b4.up_ready), 64'h1);
        chk("first_data", 64'(b4.down_data), 64'hA0);

        // Contention with single-beat packets: grant, idle, next channel, ...
        for (int k = 1; k <= 8; k++) begin
            step();
            ch    = (k / 2) % 4;
            exp_g = (k % 2 == 0) ? (4'b0001 << ch) : 4'b0000;
            chk($sformatf("cont_grant_%0d", k), 64'(grant4), 64'(exp_g));
            chk($sformatf("cont_valid_%0d", k), 64'(b4.down_valid), 64'(k % 2 == 0));
            if (k % 2 == 0) begin
                chk($sformatf("cont_data_%0d", k), 64'(b4.down_data), 64'(32'hA0 + 32'(ch)));
            end
        end
        step();
        chk("cont_release", 64'(grant4), 64'h0);
        b4.up_valid = 4'b0000;

        // ch1 sends a 5-beat packet while ch2 requests throughout; ptr is now 1.
        beat     = 0;
        model_on = 1'b1;
        set_ch1();
        b4.up_data[64 +: 32] = 32'h200;
        b4.up_last[2]        = 1'b1;
        b4.up_valid[2]       = 1'b1;
        b4.down_ready        = 1'b1;
        step();
        chk("pkt_grant_b0", 64'(grant4), 64'h2);
        chk("pkt_data_b0", 64'(b4.down_data), 64'h100);
        chk("pkt_last_b0", 64'(b4.down_last), 64'h0);
`ifdef ARB_LOCK_EN
        for (int b = 1; b <= 3; b++) begin
            step();
            chk($sformatf("lock_grant_b%0d", b), 64'(grant4), 64'h2);
            chk($sformatf("lock_data_b%0d", b), 64'(b4.down_data), 64'(32'h100 + 32'(b)));
        end
        b4.down_ready = 1'b0;
        #1;
        chk("bp_ready_low", 64'(b4.up_ready), 64'h0);
        for (int s = 0; s < 3; s++) begin
            step();
            chk($sformatf("bp_grant_%0d", s), 64'(grant4), 64'h2);
            chk($sformatf("bp_valid_%0d", s), 64'(b4.down_valid), 64'h1);
            chk($sformatf("bp_data_%0d", s), 64'(b4.down_data), 64'h103);
            chk($sformatf("bp_ready_%0d", s), 64'(b4.up_ready), 64'h0);
        end
        b4.down_ready = 1'b1;
        #1;
        chk("bp_resume_ready", 64'(b4.up_ready), 64'h2);
        step();
        chk("lock_data_b4", 64'(b4.down_data), 64'h104);
        chk("lock_last_b4", 64'(b4.down_last), 64'h1);
        chk("lock_grant_b4", 64'(grant4), 64'h2);
        step();
        chk("lock_release", 64'(grant4), 64'h0);
        step();
        chk("lock_ch2_grant", 64'(grant4), 64'h4);
        chk("lock_ch2_data", 64'(b4.down_data), 64'h200);
`else
        step();
        chk("nolock_rel_b0", 64'(grant4), 64'h0);
        step();
        chk("nolock_ch2_grant", 64'(grant4), 64'h4);
        chk("nolock_ch2_data", 64'(b4.down_data), 64'h200);
        step();
        chk("nolock_rel_ch2", 64'(grant4), 64'h0);
        step();
        chk("nolock_ch1_grant", 64'(grant4), 64'h2);
        chk("nolock_ch1_data", 64'(b4.down_data), 64'h101);
        b4.down_ready = 1'b0;
        #1;
        chk("bp_ready_low", 64'(b4.up_ready), 64'h0);
        for (int s = 0; s < 3; s++) begin
            step();
            chk($sformatf("bp_grant_%0d", s), 64'(grant4), 64'h2);
            chk($sformatf("bp_valid_%0d", s), 64'(b4.down_valid), 64'h1);
            chk($sformatf("bp_data_%0d", s), 64'(b4.down_data), 64'h101);
            chk($sformatf("bp_ready_%0d", s), 64'(b4.up_ready), 64'h0);
        end
        b4.down_ready = 1'b1;
        #1;
        chk("bp_resume_ready", 64'(b4.up_ready), 64'h2);
        step();
        chk("nolock_rel_b1", 64'(grant4), 64'h0);
        step();
        chk("nolock_ch2_again", 64'(grant4), 64'h4);
`endif

        // Granted channel drops valid: grant held, down_valid low.
        b4.up_valid[2] = 1'b0;
        step();
        chk("drop_grant_held", 64'(grant4), 64'h4);
        chk("drop_valid_low", 64'(b4.down_valid), 64'h0);
        b4.up_valid[2] = 1'b1;
        step();
        chk("drop_resume_rel", 64'(grant4), 64'h0);

        // Mid-grant async reset; ptr is 3 here.
        model_on             = 1'b0;
        b4.up_valid          = 4'b0010;
        b4.up_last           = 4'hF;
        b4.up_data[32 +: 32] = 32'hA1;
        step();
        chk("rr_wrap_ch1", 64'(grant4), 64'h2);
        step();
        chk("rr_wrap_rel", 64'(grant4), 64'h0);
        b4.up_valid   = 4'b0101;
        b4.down_ready = 1'b0;
        step();
        chk("pre_rst_grant", 64'(grant4), 64'h4);
        b4.down_ready = 1'b1;
        #1;
        chk("pre_rst_ready", 64'(b4.up_ready), 64'h4);
        rst_n = 1'b0;
        #1;
        chk("async_grant", 64'(grant4), 64'h0);
        chk("async_busy", 64'(busy4), 64'h0);
        chk("async_valid", 64'(b4.down_valid), 64'h0);
        chk("async_ready", 64'(b4.up_ready), 64'h0);
        rst_n = 1'b1;
        step();
        chk("ptr_reset_grant", 64'(grant4), 64'h1);
        b4.up_valid = 4'b0000;

        // 3-channel instance: move ptr to 2, then ch2/ch0 requesting -> ch2, ch0, ch2.
        b3.up_valid = 3'b010;
        step();
        chk("w3_ch1", 64'(grant3), 64'h2);
        step();
        chk("w3_rel1", 64'(grant3), 64'h0);
        b3.up_valid = 3'b101;
        step();
        chk("w3_ch2_a", 64'(grant3), 64'h4);
        chk("w3_data2", 64'(b3.down_data), 64'h32);
        step();
        chk("w3_rel2", 64'(grant3), 64'h0);
        step();
        chk("w3_ch0", 64'(grant3), 64'h1);
        chk("w3_data0", 64'(b3.down_data), 64'h30);
        step();
        chk("w3_rel0", 64'(grant3), 64'h0);
        step();
        chk("w3_ch2_b", 64'(grant3), 64'h4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
